// File: rtl/gpio_cfg_pkg.sv
// gpio_cfg_loader shared types and constants.
// FSM state encoding and pad word defaults.
package gpio_cfg_pkg;

  localparam int DEF_CFG_BITS = 13;

  localparam logic [DEF_CFG_BITS-1:0]
    PAD_CFG_RESET = 13'h0403;

  typedef enum logic [2:0] {
    IDLE,
    FETCH1,
    FETCH2,
    FETCH3,
    SHIFT,
    LOAD,
    DONE
  } cfg_state_t;

endpackage

// File: rtl/gpio_cfg_loader_timer.sv
// serial_phase_timer: divides clock into serial_clock
// half-periods and strobes the end of each phase and bit.
module serial_phase_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic toggle,
  output logic phase_high,
  output logic phase_end,
  output logic bit_end
);

  localparam int DW = $clog2(CLK_DIV + 1);

  logic [DW-1:0] div_cnt;

  assign phase_end = en &&
    (div_cnt == DW'(CLK_DIV - 1));
  assign bit_end = phase_end && toggle &&
    phase_high;

  // Counting with toggle low times LOAD without
  // disturbing serial_clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt    <= '0;
      phase_high <= 1'b0;
    end else if (!en) begin
      div_cnt    <= '0;
      phase_high <= 1'b0;
    end else if (phase_end) begin
      div_cnt <= '0;
      if (toggle) phase_high <= ~phase_high;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/gpio_cfg_loader.sv
// gpio_cfg_loader: fetches pad config words and shifts
// them into two pad chains, then pulses serial_load.
module gpio_cfg_loader
  import gpio_cfg_pkg::*;
#(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = DEF_CFG_BITS,
  parameter int CLK_DIV  = 2,
  localparam int AW = $clog2(NUM_PADS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       cfg_addr,
  input  logic [CFG_BITS-1:0] cfg_data,
  output logic                serial_clock,
  output logic                serial_load,
  output logic                serial_data_1,
  output logic                serial_data_2
);

  localparam int H  = NUM_PADS / 2;
  localparam int WW = (H > 1) ? $clog2(H) : 1;
  localparam int BW = $clog2(CFG_BITS);

  cfg_state_t state, state_n;

  logic [WW-1:0]       word_cnt, word_n;
  logic [BW-1:0]       bit_cnt, bit_n;
  logic [CFG_BITS-1:0] sh1, sh1_n;
  logic [CFG_BITS-1:0] sh2, sh2_n;
  logic [AW-1:0]       addr_n;

  logic t_en, t_toggle;
  logic phase_high, phase_end, bit_end;

  assign t_en     = (state == SHIFT) ||
                    (state == LOAD);
  assign t_toggle = (state == SHIFT);

  serial_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .en         (t_en),
    .toggle     (t_toggle),
    .phase_high (phase_high),
    .phase_end  (phase_end),
    .bit_end    (bit_end)
  );

  assign serial_clock = phase_high;

  always_comb begin
    state_n = state;
    word_n  = word_cnt;
    bit_n   = bit_cnt;
    sh1_n   = sh1;
    sh2_n   = sh2;
    addr_n  = cfg_addr;
    unique case (state)
      IDLE: begin
        if (start) begin
          word_n  = '0;
          addr_n  = AW'(H - 1);
          state_n = FETCH1;
        end
      end
      FETCH1: begin
        addr_n  = AW'(H + int'(word_cnt));
        state_n = FETCH2;
      end
      FETCH2: begin
        sh1_n   = cfg_data;
        state_n = FETCH3;
      end
      FETCH3: begin
        sh2_n   = cfg_data;
        bit_n   = '0;
        state_n = SHIFT;
      end
      SHIFT: begin
        if (bit_end) begin
          sh1_n = {sh1[CFG_BITS-2:0], 1'b0};
          sh2_n = {sh2[CFG_BITS-2:0], 1'b0};
          if (bit_cnt != BW'(CFG_BITS - 1)) begin
            bit_n = bit_cnt + BW'(1);
          end else if (word_cnt != WW'(H - 1)) begin
            word_n  = word_cnt + WW'(1);
            addr_n  = AW'(H - 2 - int'(word_cnt));
            state_n = FETCH1;
          end else begin
            state_n = LOAD;
          end
        end
      end
      LOAD: begin
        if (phase_end) state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so
  // they line up with the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      word_cnt      <= '0;
      bit_cnt       <= '0;
      sh1           <= CFG_BITS'(PAD_CFG_RESET);
      sh2           <= CFG_BITS'(PAD_CFG_RESET);
      cfg_addr      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      serial_load   <= 1'b0;
      serial_data_1 <= 1'b0;
      serial_data_2 <= 1'b0;
    end else begin
      state         <= state_n;
      word_cnt      <= word_n;
      bit_cnt       <= bit_n;
      sh1           <= sh1_n;
      sh2           <= sh2_n;
      cfg_addr      <= addr_n;
      busy          <= (state_n != IDLE);
      done          <= (state_n == DONE);
      serial_load   <= (state_n == LOAD);
      serial_data_1 <= (state_n == SHIFT) &&
                       sh1_n[CFG_BITS-1];
      serial_data_2 <= (state_n == SHIFT) &&
                       sh2_n[CFG_BITS-1];
    end
  end

endmodule

// File: tb/tb_gpio_cfg_loader.sv
// Scoreboard bench for gpio_cfg_loader: default and
// small-parameter instances against a register file model.
module tb_gpio_cfg_loader;

  localparam int NP = 38;
  localparam int CB = 13;
  localparam int CD = 2;
  localparam int H  = NP / 2;
  localparam int AW = $clog2(NP);
  localparam int BUSY_LEN = H * (3 + CB * 2 * CD) + CD + 1;

  localparam int NP2 = 4;
  localparam int CB2 = 3;
  localparam int CD2 = 1;
  localparam int H2  = NP2 / 2;
  localparam int AW2 = $clog2(NP2);
  localparam int BUSY2 = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;

  logic          busy, done, serial_clock, serial_load;
  logic          serial_data_1, serial_data_2;
  logic [AW-1:0] cfg_addr;
  logic [CB-1:0] cfg_data;
  logic [CB-1:0] mem [NP];

  logic           busy2, done2, sclk2, sload2, sd1_2, sd2_2;
  logic [AW2-1:0] cfg_addr2;
  logic [CB2-1:0] cfg_data2;
  logic [CB2-1:0] mem2 [NP2];

  always #5 clock = ~clock;

  gpio_cfg_loader #(
    .NUM_PADS (NP), .CFG_BITS (CB), .CLK_DIV (CD)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .serial_clock  (serial_clock),
    .serial_load   (serial_load),
    .serial_data_1 (serial_data_1),
    .serial_data_2 (serial_data_2)
  );

  gpio_cfg_loader #(
    .NUM_PADS (NP2), .CFG_BITS (CB2), .CLK_DIV (CD2)
  ) dut2 (
    .clock         (clock),
    .reset         (reset),
    .start         (start2),
    .busy          (busy2),
    .done          (done2),
    .cfg_addr      (cfg_addr2),
    .cfg_data      (cfg_data2),
    .serial_clock  (sclk2),
    .serial_load   (sload2),
    .serial_data_1 (sd1_2),
    .serial_data_2 (sd2_2)
  );

  always @(posedge clock) begin
    cfg_data  <= mem[cfg_addr];
    cfg_data2 <= mem2[cfg_addr2];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int aq[$];
  bit b1q[$];
  bit b2q[$];
  int busy_len, done_cnt, done_cyc, load_len, load_bad;
  int load_rise, load_fall, sclk_high, d1_high, d1_first;
  int rises, first_rise, last_rise, extra;
  logic [AW-1:0] addr_prev = '0;
  logic load_prev = 1'b0;
  logic sclk_prev = 1'b0;

  int aq2[$];
  bit c1q[$];
  bit c2q[$];
  int busy2_len, done2_cnt, extra2;
  logic [AW2-1:0] addr2_prev = '0;
  logic sclk2_prev = 1'b0;

  always @(negedge clock) begin
    if (!reset) begin
      if (busy) busy_len++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (serial_load) begin
        load_len++;
        if (!load_prev) load_rise = cyc;
        if (serial_clock || serial_data_1 || serial_data_2)
          load_bad++;
      end else if (load_prev) begin
        load_fall = cyc;
      end
      if (serial_clock) sclk_high++;
      if (serial_data_1) begin
        d1_high++;
        if (d1_first < 0) d1_first = cyc;
      end
      if (busy && cfg_addr != addr_prev) begin
        if (aq.size() == 0) extra++;
        else chk("cfg_addr", 32'(cfg_addr), aq.pop_front());
      end
      if (serial_clock && !sclk_prev) begin
        rises++;
        last_rise = cyc;
        if (first_rise < 0) first_rise = cyc;
        if (b1q.size() == 0) extra++;
        else begin
          chk("sd1_bit", 32'(serial_data_1), 32'(b1q.pop_front()));
          chk("sd2_bit", 32'(serial_data_2), 32'(b2q.pop_front()));
        end
      end
      if (busy2) busy2_len++;
      if (done2) done2_cnt++;
      if (busy2 && cfg_addr2 != addr2_prev) begin
        if (aq2.size() == 0) extra2++;
        else chk("cfg_addr2", 32'(cfg_addr2), aq2.pop_front());
      end
      if (sclk2 && !sclk2_prev) begin
        if (c1q.size() == 0) extra2++;
        else begin
          chk("sd1_bit2", 32'(sd1_2), 32'(c1q.pop_front()));
          chk("sd2_bit2", 32'(sd2_2), 32'(c2q.pop_front()));
        end
      end
    end
    addr_prev  = cfg_addr;
    load_prev  = serial_load;
    sclk_prev  = serial_clock;
    addr2_prev = cfg_addr2;
    sclk2_prev = sclk2;
  end

  task automatic push_exp();
    aq.delete(); b1q.delete(); b2q.delete();
    busy_len = 0; done_cnt = 0; done_cyc = 0;
    load_len = 0; load_bad = 0; load_rise = 0;
    load_fall = 0; sclk_high = 0; d1_high = 0;
    d1_first = -1; rises = 0; first_rise = -1;
    last_rise = 0; extra = 0;
    for (int w = 0; w < H; w++) begin
      aq.push_back(H - 1 - w);
      aq.push_back(H + w);
      for (int b = CB - 1; b >= 0; b--) begin
        b1q.push_back(mem[H - 1 - w][b]);
        b2q.push_back(mem[H + w][b]);
      end
    end
  endtask

  task automatic run1(input int restart_at);
    int k;
    push_exp();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    k = 1;
    while (!done && k < 3000) begin
      @(negedge clock);
      k++;
      start = (k == restart_at);
    end
    start = 1'b0;
    chk("done_cycle", k, BUSY_LEN);
    repeat (2) @(negedge clock);
    chk("busy_len", busy_len, BUSY_LEN);
    chk("done_cnt", done_cnt, 1);
    chk("addr_left", aq.size(), 0);
    chk("bits_left", b1q.size(), 0);
    chk("extra_events", extra, 0);
    chk("rises", rises, CB * H);
    chk("sclk_high", sclk_high, CB * H * CD);
    chk("load_len", load_len, CD);
    chk("load_quiet", load_bad, 0);
    chk("load_after_rise", load_rise - last_rise, CD);
    chk("done_after_load", done_cyc - load_fall, 0);
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {busy, done, cfg_addr, serial_clock,
              serial_load, serial_data_1, serial_data_2}, 0);
  endtask

  initial begin
    int k;
    for (int p = 0; p < NP; p++)
      mem[p] = CB'((p * 257) % 8192);
    for (int p = 0; p < NP2; p++)
      mem2[p] = CB2'((p * 3 + 5) % 8);

    repeat (3) @(negedge clock);
    chk_idle("reset_outputs");
    chk("reset_outputs2", {busy2, done2, cfg_addr2, sclk2,
                           sload2, sd1_2, sd2_2}, 0);
    reset = 1'b0;
    @(negedge clock);
    chk_idle("idle_outputs");

    run1(0);
    run1(500);

    for (int p = 0; p < NP; p++) mem[p] = '0;
    mem[18] = 13'h1fff;
    run1(0);
    chk("d1_high", d1_high, CB * 2 * CD);
    chk("data_to_rise", first_rise - d1_first, CD);

    for (int p = 0; p < NP; p++)
      mem[p] = CB'((p * 257) % 8192);
    push_exp();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (299) @(negedge clock);
    chk("busy_before_reset", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk_idle("reset_mid_shift");
    chk("no_partial_load", load_len, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk_idle("after_reset");
    run1(0);

    aq2.delete(); c1q.delete(); c2q.delete();
    busy2_len = 0; done2_cnt = 0; extra2 = 0;
    for (int w = 0; w < H2; w++) begin
      aq2.push_back(H2 - 1 - w);
      aq2.push_back(H2 + w);
      for (int b = CB2 - 1; b >= 0; b--) begin
        c1q.push_back(mem2[H2 - 1 - w][b]);
        c2q.push_back(mem2[H2 + w][b]);
      end
    end
    @(negedge clock); start2 = 1'b1;
    @(negedge clock); start2 = 1'b0;
    k = 1;
    while (!done2 && k < 200) begin
      @(negedge clock);
      k++;
    end
    chk("done_cycle2", k, BUSY2);
    repeat (2) @(negedge clock);
    chk("busy_len2", busy2_len, BUSY2);
    chk("done_cnt2", done2_cnt, 1);
    chk("addr_left2", aq2.size(), 0);
    chk("bits_left2", c1q.size(), 0);
    chk("extra_events2", extra2, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_cfg_loader.md
# gpio_cfg_loader

Sequencer that loads the per-pad configuration words (mode, output-enable, input-disable, drive mode and related controls) into the user-project pad control blocks over two serial chains. It sits in housekeeping, between the configuration register file and the pad controllers that drive the `mprj_io` pad array. On `start` it fetches each pad's word and shifts both chains in parallel, then issues a load strobe so every pad updates at once.

## Interface
- `NUM_PADS`, 38: number of user pads. Must be even.
- `CFG_BITS`, 13: bits per pad configuration word.
- `CLK_DIV`, 2: `clock` cycles per `serial_clock` half-period. Must be ≥1.
- `clock` input 1: single clock for the block.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: single-cycle request to begin a load. Ignored while `busy`.
- `busy` output 1: high from the cycle after an accepted `start` through the `done` cycle, inclusive.
- `done` output 1: one-cycle pulse when the load completes.
- `cfg_addr` output $clog2(NUM_PADS): pad index presented to the register file.
- `cfg_data` input CFG_BITS: word for `cfg_addr`. Valid exactly 1 cycle after the address is presented.
- `serial_clock` output 1: shift clock to both chains. Pads sample on its rising edge.
- `serial_load` output 1: transfer strobe. Pads latch their shadow registers while it is high.
- `serial_data_1` output 1: data for chain 1, covering pads 0..H-1, where H = NUM_PADS/2.
- `serial_data_2` output 1: data for chain 2, covering pads NUM_PADS-1 down to H.

## Operation
- States: IDLE → FETCH1 → FETCH2 → FETCH3 → SHIFT → (next word: FETCH1 | last word: LOAD) → DONE → IDLE.
- **Reset values.** All outputs are 0. State is IDLE and all counters are 0.
- **IDLE.** When `start`=1, clear `word_cnt` and go to FETCH1.
- **Word ordering.** Word index w runs 0..H-1.
  - Chain 1 pad index is H-1-w, so the farthest pad is shifted first.
  - Chain 2 pad index is H+w.
- **FETCH1.** `cfg_addr` = chain-1 pad index.
- **FETCH2.** Capture `cfg_data` into `sh1`. `cfg_addr` = chain-2 pad index.
- **FETCH3.** Capture `cfg_data` into `sh2`. Clear `bit_cnt` and `div_cnt`.
- **cfg_addr in other states.** Holds its last value (0 after reset).
- **SHIFT.** Each bit takes 2·CLK_DIV cycles.
  - First CLK_DIV cycles: `serial_clock`=0.
  - Next CLK_DIV cycles: `serial_clock`=1.
  - `serial_data_1`/`serial_data_2` show MSB of `sh1`/`sh2` and stay stable for the whole bit period.
  - On the last cycle of the high phase, shift both registers left by 1 and increment `bit_cnt`.
  - After bit CFG_BITS-1: if w < H-1, increment `word_cnt` and go to FETCH1; otherwise go to LOAD.
- **LOAD.** `serial_load`=1 for CLK_DIV cycles. `serial_clock` and both data outputs are 0.
- **DONE.** `done`=1 for one cycle, then IDLE.
- **`start` while busy.** Has no effect; there is no queueing.
- **Reset mid-operation.** Outputs drop to 0 immediately. `serial_load` is never asserted for a partial load, so pads keep their previous configuration. A new `start` is required.
- **Counter widths.** `div_cnt` is $clog2(CLK_DIV+1) bits, `bit_cnt` is $clog2(CFG_BITS) bits, `word_cnt` is $clog2(H) bits. No counter wraps outside its defined range.

## Timing
- `start` is sampled at edge 0. `busy` rises and FETCH1 begins in the next cycle.
- Per word: 3 + CFG_BITS·2·CLK_DIV cycles.
- Total `busy` duration: H·(3 + CFG_BITS·2·CLK_DIV) + CLK_DIV + 1 cycles.
  - Default parameters: 19·55 + 2 + 1 = 1048 cycles.
- `serial_clock` is 0 during FETCH states, so there are no spurious edges between words.
- The last rising edge of `serial_clock` precedes `serial_load` rising by CLK_DIV cycles.
- All outputs are registered. No combinational path from `start` or `cfg_data` to any output.

## Structure
- Package `gpio_cfg_pkg` holds:
  - the state enum `cfg_state_t` (IDLE, FETCH1, FETCH2, FETCH3, SHIFT, LOAD, DONE);
  - the default `CFG_BITS`;
  - the reset constant for pad words.
- Sub-module `serial_phase_timer` owns `div_cnt` and the `serial_clock` phase. It outputs `phase_high` and `bit_end` strobes. The top-level FSM and shift registers consume these strobes.

## Test plan
- **Basic load.** Defaults; register file word(p) = p·0x101 mod 0x2000; pulse `start`.
  - `cfg_addr` sequence is 18, 19, 17, 20, …, 0, 37.
  - Chain 1 receives 0x1212 MSB-first first.
  - `busy` lasts 1048 cycles; `done` pulses once.
- **Bit timing.** Defaults, word 0x1FFF on pad 18.
  - `serial_data_1` is high for 13·4 = 52 cycles.
  - `serial_clock` has exactly 13 rising edges, each 2 cycles after the data changes.
- **Start while busy.** Pulse `start` again at cycle 500.
  - Exactly one `done`, at cycle 1048.
  - No restart of `cfg_addr`.
- **Reset mid-shift.** Assert `reset` at cycle 300.
  - All outputs are 0 in the same cycle.
  - `serial_load` is never high.
  - A following `start` completes normally in 1048 cycles.
- **Parameter corner.** CLK_DIV=1, NUM_PADS=4, CFG_BITS=3.
  - `busy` lasts 2·(3+6) + 1 + 1 = 20 cycles.
  - `cfg_addr` sequence is 1, 2, 0, 3.
- **Load pulse.** Defaults.
  - `serial_load` is high for exactly 2 cycles, with `serial_clock`=0 throughout.
  - `done` pulses in the cycle after `serial_load` falls.
